// File: rtl/regbank_write_ctrl.sv
// Write-port arbiter and clear sequencer for a bank of write-enabled registers.
// Build option REGBANK_ROUND_ROBIN_EN selects round-robin tie breaking (default: A has fixed priority).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | arbitrate REQ_A / REQ_B, or start a sweep when SWEEP is high
// ST_SWEEP | present WEN for register cnt with zero data, one register per cycle
module regbank_write_ctrl #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             REQ_A,
  input  logic [AW-1:0]    ADDR_A,
  input  logic [WIDTH-1:0] DATA_A,
  input  logic             REQ_B,
  input  logic [AW-1:0]    ADDR_B,
  input  logic [WIDTH-1:0] DATA_B,
  input  logic             SWEEP,
  output logic             ACK_A,
  output logic             ACK_B,
  output logic [NREGS-1:0] WEN,
  output logic [WIDTH-1:0] DOUT,
  output logic             BUSY
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_SWEEP = 1'b1;
  localparam logic [NREGS-1:0] WEN_ONE  = {{(NREGS-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]    CNT_LAST = AW'(NREGS-1);

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic          grant_a;
  logic          grant_b;

`ifdef REGBANK_ROUND_ROBIN_EN
  logic last_b;

  // On a tie, A wins only when B was the most recent grant.
  assign grant_a = REQ_A && (!REQ_B || last_b);
`else
  assign grant_a = REQ_A;
`endif
  assign grant_b = REQ_B && !grant_a;

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ACK_A <= 1'b0;
      ACK_B <= 1'b0;
      WEN   <= '0;
      DOUT  <= '0;
      BUSY  <= 1'b0;
`ifdef REGBANK_ROUND_ROBIN_EN
      last_b <= 1'b1;
`endif
    end else begin
      ACK_A <= 1'b0;
      ACK_B <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (SWEEP) begin
            state <= ST_SWEEP;
            BUSY  <= 1'b1;
            cnt   <= '0;
            WEN   <= WEN_ONE;
            DOUT  <= '0;
          end else if (grant_a) begin
            WEN   <= WEN_ONE << ADDR_A;
            DOUT  <= DATA_A;
            ACK_A <= 1'b1;
`ifdef REGBANK_ROUND_ROBIN_EN
            last_b <= 1'b0;
`endif
          end else if (grant_b) begin
            WEN   <= WEN_ONE << ADDR_B;
            DOUT  <= DATA_B;
            ACK_B <= 1'b1;
`ifdef REGBANK_ROUND_ROBIN_EN
            last_b <= 1'b1;
`endif
          end else begin
            WEN <= '0;
          end
        end
        default: begin
          // cnt wraps to zero on the same edge the sweep hands back to IDLE.
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            WEN   <= '0;
          end else begin
            WEN <= WEN_ONE << (cnt + 1'b1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_write_ctrl.sv
// Bench for regbank_write_ctrl: vector table, hand-written corner sequences and
// randomized requesters checked against a queue-based reference model.
module tb_regbank_write_ctrl;

  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam int WIDTH = 8;
`ifdef REGBANK_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             C = 1'b0;
  logic             CLR;
  logic             REQ_A, REQ_B, SWEEP;
  logic [AW-1:0]    ADDR_A, ADDR_B;
  logic [WIDTH-1:0] DATA_A, DATA_B;
  logic             ACK_A, ACK_B, BUSY;
  logic [NREGS-1:0] WEN;
  logic [WIDTH-1:0] DOUT;

  int n_cmp  = 0;
  int n_fail = 0;

  regbank_write_ctrl #(.NREGS(NREGS), .AW(AW), .WIDTH(WIDTH)) dut (
    .C(C), .CLR(CLR),
    .REQ_A(REQ_A), .ADDR_A(ADDR_A), .DATA_A(DATA_A),
    .REQ_B(REQ_B), .ADDR_B(ADDR_B), .DATA_B(DATA_B),
    .SWEEP(SWEEP),
    .ACK_A(ACK_A), .ACK_B(ACK_B), .WEN(WEN), .DOUT(DOUT), .BUSY(BUSY)
  );

  always #5 C = ~C;

  typedef struct {
    logic             ra;
    logic [AW-1:0]    aa;
    logic [WIDTH-1:0] da;
    logic             rb;
    logic [AW-1:0]    ab;
    logic [WIDTH-1:0] db;
    logic [NREGS-1:0] wen;
    logic [WIDTH-1:0] dout;
    logic             ka;
    logic             kb;
  } vec_t;

  typedef struct {
    logic [NREGS-1:0] wen;
    logic [WIDTH-1:0] dout;
    logic             ka;
    logic             kb;
    logic             busy;
  } out_t;

  vec_t vt[6];
  out_t sched[$];
  out_t e;
  bit   m_last_b;
  logic [WIDTH-1:0] m_dout;
  logic [NREGS-1:0] one8 = 8'h01;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic [7:0] w, input logic [7:0] d,
                         input logic ka, input logic kb, input logic bz);
    chk8({nm, ".wen"}, WEN, w);
    chk8({nm, ".dout"}, DOUT, d);
    chk1({nm, ".ack_a"}, ACK_A, ka);
    chk1({nm, ".ack_b"}, ACK_B, kb);
    chk1({nm, ".busy"}, BUSY, bz);
  endtask

  task automatic idle_inputs();
    REQ_A = 0; REQ_B = 0; SWEEP = 0;
    ADDR_A = '0; ADDR_B = '0; DATA_A = '0; DATA_B = '0;
  endtask

  // CLR raised mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string nm);
    @(negedge C);
    #2 CLR = 1;
    #1 chk_out(nm, 8'h00, 8'h00, 0, 0, 0);
    @(negedge C);
    CLR = 0;
  endtask

  // Reference model: one call per rising edge, from the inputs held at that edge.
  task automatic model_step();
    bit ga, gb;
    if (sched.size() > 0) begin
      e = sched.pop_front();
    end else if (SWEEP) begin
      for (int k = 0; k < NREGS; k++)
        sched.push_back('{wen: one8 << k, dout: 8'h00, ka: 0, kb: 0, busy: 1});
      sched.push_back('{wen: 8'h00, dout: 8'h00, ka: 0, kb: 0, busy: 0});
      e = sched.pop_front();
      m_dout = 8'h00;
    end else begin
      ga = REQ_A && (!REQ_B || !RR || m_last_b);
      gb = REQ_B && !ga;
      if (ga) begin
        e = '{wen: one8 << ADDR_A, dout: DATA_A, ka: 1, kb: 0, busy: 0};
        m_dout = DATA_A; m_last_b = 0;
      end else if (gb) begin
        e = '{wen: one8 << ADDR_B, dout: DATA_B, ka: 0, kb: 1, busy: 0};
        m_dout = DATA_B; m_last_b = 1;
      end else begin
        e = '{wen: 8'h00, dout: m_dout, ka: 0, kb: 0, busy: 0};
      end
    end
  endtask

  initial begin
    CLR = 1;
    idle_inputs();
    #12;
    chk_out("por", 8'h00, 8'h00, 0, 0, 0);
    @(negedge C);
    CLR = 0;

    // ---- vector table: back-to-back single requests from IDLE ----
    vt[0] = '{1, 3'd5, 8'hA5, 0, 3'd0, 8'h00, 8'h20, 8'hA5, 1, 0};
    vt[1] = '{0, 3'd0, 8'h00, 1, 3'd0, 8'h3C, 8'h01, 8'h3C, 0, 1};
    vt[2] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h3C, 0, 0};
    vt[3] = '{0, 3'd0, 8'h00, 1, 3'd7, 8'hFF, 8'h80, 8'hFF, 0, 1};
    vt[4] = '{1, 3'd2, 8'h00, 0, 3'd0, 8'h00, 8'h04, 8'h00, 1, 0};
    vt[5] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0};
    do_reset("rst0");
    for (int i = 0; i < 6; i++) begin
      REQ_A = vt[i].ra; ADDR_A = vt[i].aa; DATA_A = vt[i].da;
      REQ_B = vt[i].rb; ADDR_B = vt[i].ab; DATA_B = vt[i].db;
      @(negedge C);
      chk_out($sformatf("vec%0d", i), vt[i].wen, vt[i].dout, vt[i].ka, vt[i].kb, 0);
    end
    idle_inputs();

    // ---- tie, both held ----
    do_reset("rst_tie");
    REQ_A = 1; ADDR_A = 3'd1; DATA_A = 8'h5A;
    REQ_B = 1; ADDR_B = 3'd2; DATA_B = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      @(negedge C);
      chk_out($sformatf("tie%0d", i),
              (RR && i % 2 == 1) ? 8'h04 : 8'h02,
              (RR && i % 2 == 1) ? 8'hC3 : 8'h5A,
              !(RR && i % 2 == 1), RR && i % 2 == 1, 0);
    end
    idle_inputs();

    // ---- sweep with B pending ----
    do_reset("rst_sw");
    SWEEP = 1; REQ_B = 1; ADDR_B = 3'd6; DATA_B = 8'h77;
    for (int i = 0; i < NREGS; i++) begin
      @(negedge C);
      SWEEP = 0;
      chk_out($sformatf("sweep%0d", i), one8 << i, 8'h00, 0, 0, 1);
    end
    @(negedge C);
    chk_out("sweep_exit", 8'h00, 8'h00, 0, 0, 0);
    @(negedge C);
    chk_out("sweep_b", 8'h40, 8'h77, 0, 1, 0);
    idle_inputs();
    @(negedge C);
    chk_out("sweep_b_done", 8'h00, 8'h77, 0, 0, 0);

    // ---- reset mid-sweep, then restart ----
    SWEEP = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge C);
      SWEEP = 0;
      chk_out($sformatf("msw%0d", i), one8 << i, 8'h00, 0, 0, 1);
    end
    do_reset("rst_msw");
    @(negedge C);
    chk_out("msw_idle", 8'h00, 8'h00, 0, 0, 0);
    SWEEP = 1;
    @(negedge C);
    SWEEP = 0;
    chk_out("msw_restart0", 8'h01, 8'h00, 0, 0, 1);
    @(negedge C);
    chk_out("msw_restart1", 8'h02, 8'h00, 0, 0, 1);
    for (int k = 0; k < 20 && BUSY; k++) @(negedge C);
    chk1("msw_done", BUSY, 0);

    // ---- same-address race, requesters drop on their ACK ----
    do_reset("rst_race");
    REQ_A = 1; ADDR_A = 3'd3; DATA_A = 8'h11;
    REQ_B = 1; ADDR_B = 3'd3; DATA_B = 8'h22;
    @(negedge C);
    chk_out("race0", 8'h08, 8'h11, 1, 0, 0);
    REQ_A = 0;
    @(negedge C);
    chk_out("race1", 8'h08, 8'h22, 0, 1, 0);
    REQ_B = 0;
    @(negedge C);
    chk_out("race2", 8'h00, 8'h22, 0, 0, 0);

    // ---- randomized requesters against the reference model ----
    do_reset("rst_rand");
    sched.delete();
    m_last_b = 1;
    m_dout = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      @(posedge C);
      model_step();
      @(negedge C);
      chk_out($sformatf("rnd%0d", i), e.wen, e.dout, e.ka, e.kb, e.busy);
      if (!REQ_A || e.ka) begin
        REQ_A  = ($urandom_range(0, 99) < 55);
        ADDR_A = AW'($urandom);
        DATA_A = WIDTH'($urandom);
      end
      if (!REQ_B || e.kb) begin
        REQ_B  = ($urandom_range(0, 99) < 55);
        ADDR_B = AW'($urandom);
        DATA_B = WIDTH'($urandom);
      end
      SWEEP = ($urandom_range(0, 99) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_write_ctrl.md
Name: regbank_write_ctrl

Overview:
- Write controller and arbiter for a bank of write-enabled registers (NREGS words of WIDTH bits, each built from per-bit flops with a write-enable input).
- Shares the single bank write port between two requesters (A and B) and generates the one-hot per-register write enables and the shared data bus.
- Also runs a sequenced clear sweep that writes zero to every register, one per cycle, for software-visible initialisation without asserting the flops' asynchronous clears.

Parameters:
- NREGS, 8, number of registers in the bank (power of two, >= 2)
- AW, 3, register address width (log2 NREGS)
- WIDTH, 8, data width per register

Ports:
- C  input  1  clock; all state updates on rising edge
- CLR  input  1  asynchronous active-high reset
- REQ_A  input  1  requester A write request; held until ACK_A
- ADDR_A  input  AW  requester A target register
- DATA_A  input  WIDTH  requester A write data
- REQ_B  input  1  requester B write request; held until ACK_B
- ADDR_B  input  AW  requester B target register
- DATA_B  input  WIDTH  requester B write data
- SWEEP  input  1  start clear sweep (level, sampled in IDLE only)
- ACK_A  output  1  one-cycle pulse: A's write issued
- ACK_B  output  1  one-cycle pulse: B's write issued
- WEN  output  NREGS  one-hot per-register write enable, 1-cycle pulse
- DOUT  output  WIDTH  data to the bank write inputs
- BUSY  output  1  high while a sweep is in progress

Behaviour:
- Reset (CLR=1, async): state=IDLE, ACK_A=0, ACK_B=0, WEN=0, DOUT=0, BUSY=0, sweep counter=0, last_grant=B (A wins the first tie).
- All outputs are registered. A request sampled at edge k produces WEN/DOUT/ACK valid during cycle k..k+1. Latency is 1 cycle; the bank captures on the next edge.
- At most one WEN bit is high in any cycle. WEN and DOUT change only together.
- States: IDLE, SWEEP.
- IDLE, SWEEP=1: go to SWEEP, BUSY=1, counter=0. SWEEP takes priority over pending REQ_A/REQ_B, which are held un-acked.
- IDLE, one request: grant it; WEN=1<<ADDR, DOUT=DATA, ACK pulse for that requester.
- IDLE, both requests: arbitrate (see Optional Feature). The loser stays pending and is granted on a later cycle; no request is dropped.
- IDLE, no request: WEN=0, ACKs=0, DOUT holds its last value.
- Back-to-back grants are allowed. A requester whose REQ stays high in the cycle after its ACK is treated as a new request.
- SWEEP state: each cycle WEN=1<<counter, DOUT=0, counter increments. After the WEN for register NREGS-1 is issued, return to IDLE; BUSY drops on that same edge. The sweep takes exactly NREGS cycles. No ACKs are issued during SWEEP. SWEEP input is ignored while in SWEEP.
- Address wrap: the counter is AW bits wide; its wrap to 0 coincides with the exit to IDLE.
- CLR asserted mid-sweep or mid-grant: immediate return to reset values. A partially issued sweep is abandoned and not resumed.
- Both requesters targeting the same address: serialised. The later grant's data wins in the bank.

Optional Feature:
- Macro: REGBANK_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On a tie, grant the requester not granted last. last_grant updates on every grant; sweeps do not change it.
- Undefined: fixed priority, A always beats B on a tie. B can starve under continuous A traffic. The last_grant register is removed.

Test Plan:
- Reset: assert CLR mid-cycle -> all outputs 0 immediately, without waiting for an edge; BUSY=0.
- Single write: REQ_A=1, ADDR_A=5, DATA_A=8'hA5 -> next edge WEN=8'b0010_0000, DOUT=8'hA5, ACK_A=1 for one cycle, then WEN=0.
- Tie: REQ_A=REQ_B=1 held, ADDR_A=1, ADDR_B=2.
  - With REGBANK_ROUND_ROBIN_EN: grants alternate A, B, A, B with WEN 8'h02, 8'h04, ...
  - Without the macro: A is granted every cycle while REQ_A stays high, and ACK_B never pulses.
- Sweep: SWEEP=1 in IDLE with REQ_B pending -> 8 cycles of WEN=8'h01, 8'h02 ... 8'h80 with DOUT=0 and BUSY=1; then BUSY=0 and B is acked on the next cycle.
- Reset mid-sweep: CLR after the third sweep cycle -> WEN=0, BUSY=0. A new SWEEP restarts at WEN=8'h01.
- Same-address race: A and B both target register 3, with DATA 8'h11 and 8'h22 -> two separate WEN=8'h08 pulses in successive cycles, carrying the DOUT values in grant order.
